lsu_stage: RTL
==============

Name: lsu_stage

Overview:
- Load/store and writeback stage directly downstream of the execute stage.
- Consumes the EX->LSU bundle (register-write result or memory access request).
- Drives a single-outstanding req/ack data-memory bus, performs byte-lane steering and load sign/zero extension, and produces the register-file writeback.
- Stalls upstream while a memory access is in flight; reports misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16, cycles without i_mem_ack before the access is aborted with o_bus_error.
- ADDR_WIDTH, 32, width of the data-memory address.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_valid  input  1  EX bundle valid this cycle.
- i_is_reg_write  input  1  instruction writes rd.
- i_is_mem_read  input  1  load.
- i_is_mem_write  input  1  store.
- i_mem_address  input  32  byte address of the access.
- i_rd_id  input  5  destination register.
- i_mem_data  input  32  store data, right-justified.
- i_reg_data  input  32  ALU result for non-load writes.
- i_load_store_type  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- o_stall  output  1  upstream must hold its bundle.
- o_mem_req  output  1  bus request.
- o_mem_we  output  1  1 = write.
- o_mem_addr  output  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
- o_mem_wdata  output  32  lane-steered store data.
- o_mem_be  output  4  byte enables.
- i_mem_ack  input  1  bus completion; one cycle per request.
- i_mem_rdata  input  32  read word, valid with ack.
- o_wb_enable  output  1  register-file write strobe.
- o_wb_rd_id  output  5  writeback register.
- o_wb_data  output  32  writeback data.
- o_misaligned  output  1  one-cycle pulse on a misaligned access.
- o_bus_error  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset: every output is 0. State is IDLE. Timeout counter is 0.
- Reset asserted mid-access: the access is abandoned, o_mem_req drops on the next edge, and no writeback occurs.

States: IDLE, MEM_WAIT.

IDLE, i_valid with no mem access and i_is_reg_write:
- Next cycle: o_wb_enable=1, o_wb_rd_id=i_rd_id, o_wb_data=i_reg_data. Latency 1.

Misalignment:
- H access with addr[0]=1 is misaligned.
- W access with addr[1:0]!=0 is misaligned.
- On a misaligned access: no bus request, no writeback, o_misaligned pulses next cycle, state stays IDLE.

IDLE, i_valid with an aligned mem access:
- Latch addr, data, type, rd, and read/write.
- Next cycle enter MEM_WAIT with o_mem_req=1.
- o_stall is combinational: 1 in this accept cycle and throughout MEM_WAIT, until the cycle ack is seen.

Store lanes:
- SB: wdata = {4{byte}}, be = 0001 << addr[1:0].
- SH: wdata = {2{half}}, be = 0011 << addr[1:0].
- SW: be = 1111.

MEM_WAIT:
- o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata and o_mem_be are held stable until ack.
- On i_mem_ack: o_mem_req=0 next cycle, state returns to IDLE, o_stall deasserts in the ack cycle.
- Load completion: writeback next cycle with extracted data.
  - Byte: rdata >> (8*addr[1:0]).
  - Half: rdata >> (8*addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - An undefined funct3 is treated as W.
- Store completion: no writeback.

Timeout:
- The counter increments each MEM_WAIT cycle without ack.
- When it reaches TIMEOUT_CYCLES-1 with no ack: abort, o_mem_req=0, o_bus_error pulses, return to IDLE, no writeback.
- If ack arrives in the terminal cycle, ack wins.

Writeback to x0:
- rd_id==0 suppresses o_wb_enable in all cases.
- The bus access still occurs.

Other rules:
- o_wb_enable is a one-cycle pulse.
- i_valid is ignored while in MEM_WAIT.
- i_mem_ack outside MEM_WAIT is ignored.

Decomposition:
- Shared package lsu_pkg:
  - load_store_type_t enum: LB/LH/LW/LBU/LHU, SB/SH/SW aliases.
  - lsu_state_t (IDLE, MEM_WAIT).
- One natural sub-module: lsu_load_align, purely combinational (rdata, addr[1:0], type -> 32-bit extended result).
- Store lane steering stays inline.

Test Plan:
- ALU write: i_is_reg_write=1, rd=5, reg_data=0x1234 -> next cycle wb_enable=1, rd=5, data=0x00001234, o_stall never 1.
- LB sign-extend: addr=0x103, rdata=0x80FFFFFF, ack after 3 cycles -> o_mem_addr=0x100, stall 4 cycles, wb_data=0xFFFFFF80.
- LHU: addr=0x202, rdata=0xBEEF0000 -> wb_data=0x0000BEEF.
- SB: addr=0x301, data=0xAB -> be=0010, wdata=0xABABABAB, we=1, no wb after ack.
- Misaligned LW: addr=0x6 -> o_misaligned pulse, o_mem_req stays 0, no wb.
- Timeout: LW, ack withheld -> o_bus_error after TIMEOUT_CYCLES cycles in MEM_WAIT, req drops, stall releases. Repeat with reset asserted mid-wait -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: access-type, state and size definitions shared by the load/store stage.
package lsu_pkg;
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_store_type_t;

    localparam load_store_type_t SB = LB;
    localparam load_store_type_t SH = LH;
    localparam load_store_type_t SW = LW;

    typedef enum logic {IDLE, MEM_WAIT} lsu_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

    // Undefined funct3 encodings fall through to word size.
    function automatic lsu_size_t lsu_size(input logic [2:0] t);
        return (t[1:0] == 2'b00) ? SZ_B : (t[1:0] == 2'b01) ? SZ_H : SZ_W;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] t, input logic [1:0] a);
        return (lsu_size(t) == SZ_H && a[0]) || (lsu_size(t) == SZ_W && a != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: extracts and sign/zero-extends the addressed lanes of a read word.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_type,
    output logic [31:0] o_data
);
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic        w_signed;

    always_comb begin
        w_half   = 16'(i_rdata >> {i_offset, 3'b000});
        w_byte   = w_half[7:0];
        w_signed = ~i_type[2];
        o_data   = (lsu_size(i_type) == SZ_B) ? {{24{w_signed & w_byte[7]}}, w_byte}
                 : (lsu_size(i_type) == SZ_H) ? {{16{w_signed & w_half[15]}}, w_half}
                 : i_rdata;
    end
endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: load/store + writeback stage with a single-outstanding req/ack data bus.
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic                  i_is_reg_write,
    input  logic                  i_is_mem_read,
    input  logic                  i_is_mem_write,
    input  logic [31:0]           i_mem_address,
    input  logic [4:0]            i_rd_id,
    input  logic [31:0]           i_mem_data,
    input  logic [31:0]           i_reg_data,
    input  logic [2:0]            i_load_store_type,
    output logic                  o_stall,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic [3:0]            o_mem_be,
    input  logic                  i_mem_ack,
    input  logic [31:0]           i_mem_rdata,
    output logic                  o_wb_enable,
    output logic [4:0]            o_wb_rd_id,
    output logic [31:0]           o_wb_data,
    output logic                  o_misaligned,
    output logic                  o_bus_error
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t            r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [2:0]            r_type;
    logic [4:0]            r_rd;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic                  r_wb_en, r_mis, r_berr;
    logic [4:0]            r_wb_rd;
    logic [31:0]           r_wb_data;

    logic                  w_mem, w_mis, w_accept, w_done, w_timeout;
    lsu_size_t             w_sz;
    logic [1:0]            w_off;
    logic [31:0]           w_sdata, w_load;
    logic [3:0]            w_sbe;

    assign w_mem     = i_is_mem_read | i_is_mem_write;
    assign w_mis     = lsu_misaligned(i_load_store_type, i_mem_address[1:0]);
    assign w_accept  = r_state == IDLE && i_valid && w_mem && !w_mis;
    assign w_done    = r_state == MEM_WAIT && i_mem_ack;
    assign w_timeout = r_state == MEM_WAIT && !i_mem_ack && r_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign w_sz      = lsu_size(i_load_store_type);
    assign w_off     = i_mem_address[1:0];
    assign w_sdata   = (w_sz == SZ_B) ? {4{i_mem_data[7:0]}}
                     : (w_sz == SZ_H) ? {2{i_mem_data[15:0]}} : i_mem_data;
    assign w_sbe     = (w_sz == SZ_B) ? 4'b0001 << w_off
                     : (w_sz == SZ_H) ? 4'b0011 << w_off : 4'b1111;

    lsu_load_align u_align (
        .i_rdata  (i_mem_rdata),
        .i_offset (r_addr[1:0]),
        .i_type   (r_type),
        .o_data   (w_load)
    );

    always_ff @(posedge i_clk) begin
        r_state <= !i_rst_n ? IDLE : w_next;
    end

    // Stall drops in the completing cycle so the held bundle is not re-issued.
    always_comb begin
        w_next  = r_state;
        o_stall = 1'b0;
        w_next  = w_accept ? MEM_WAIT : (w_done || w_timeout) ? IDLE : r_state;
        o_stall = i_rst_n && (w_accept || (r_state == MEM_WAIT && !i_mem_ack && !w_timeout));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_type    <= 3'b000;
            r_rd      <= 5'd0;
            r_wdata   <= 32'd0;
            r_be      <= 4'd0;
            r_wb_en   <= 1'b0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= 32'd0;
            r_mis     <= 1'b0;
            r_berr    <= 1'b0;
        end else begin
            r_wb_en <= 1'b0;
            r_mis   <= 1'b0;
            r_berr  <= w_timeout;
            r_cnt   <= (r_state == MEM_WAIT) ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_addr  <= i_mem_address[ADDR_WIDTH-1:0];
                r_we    <= i_is_mem_write;
                r_type  <= i_load_store_type;
                r_rd    <= i_rd_id;
                r_wdata <= w_sdata;
                r_be    <= w_sbe;
            end
            if (r_state == IDLE && i_valid && !w_mem && i_is_reg_write) begin
                r_wb_en   <= i_rd_id != 5'd0;
                r_wb_rd   <= i_rd_id;
                r_wb_data <= i_reg_data;
            end
            if (r_state == IDLE && i_valid && w_mem && w_mis)
                r_mis <= 1'b1;
            if (w_done && !r_we) begin
                r_wb_en   <= r_rd != 5'd0;
                r_wb_rd   <= r_rd;
                r_wb_data <= w_load;
            end
        end
    end

    assign o_mem_req    = r_state == MEM_WAIT;
    assign o_mem_we     = r_we;
    assign o_mem_addr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign o_mem_wdata  = r_wdata;
    assign o_mem_be     = r_be;
    assign o_wb_enable  = r_wb_en;
    assign o_wb_rd_id   = r_wb_rd;
    assign o_wb_data    = r_wb_data;
    assign o_misaligned = r_mis;
    assign o_bus_error  = r_berr;
endmodule
